// File: rtl/div_seq.sv
// div_seq -- iterative restoring divider, one quotient bit per clock, MSB first.
//
// Computes q = floor(a / b) and r = a mod b for an unsigned 2N-bit dividend
// and N-bit divisor. A divide by zero returns q = all ones, r = 0, dz = 1.
// The operand handshake is valid/ready, and so is the result handshake.
// The result registers keep the last delivered result until the next
// result or a reset.
//
// Build option:
//   DIV_SEQ_DZ_FAST_EN  when defined, a zero divisor goes straight from the
//                       accept edge to DONE. When undefined, a zero divisor
//                       runs the full 2N-cycle BUSY phase like any other
//                       operand pair.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block can accept an operand pair (IDLE only)
//   a          unsigned dividend, 2N bits
//   b          unsigned divisor, N bits
//   out_valid  result on q/r/dz is valid (DONE only)
//   out_ready  consumer accepts the result
//   q          quotient, 2N bits
//   r          remainder, N bits
//   dz         divide-by-zero flag
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready = 1
// BUSY  | resolving one quotient bit per cycle, 2N cycles
// DONE  | result presented, out_valid = 1, held until out_ready

module div_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           dz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int            CW   = $clog2(2*N);
  localparam logic [CW-1:0] LAST = CW'(2*N-1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] a_sh;
  logic [N-1:0]   b_reg;
  logic [N:0]     rem;
  logic [N:0]     rem_shift;
  logic [N:0]     rem_nxt;
  logic           ge;
  logic [2*N-1:0] a_nxt;

  // Restoring step. The dividend shifts out from its MSB into the partial
  // remainder, and the quotient bits shift in at its LSB. After 2N steps,
  // a_sh holds the quotient. If rem[N] is set, the shifted value is already
  // at least 2^(N+1), which is larger than any divisor. The N+1-bit
  // difference is still exact, because the true result is below b.
  always_comb begin
    rem_shift = {rem[N-1:0], a_sh[2*N-1]};
    ge        = rem[N] | (rem_shift >= {1'b0, b_reg});
    rem_nxt   = ge ? (rem_shift - {1'b0, b_reg}) : rem_shift;
    a_nxt     = {a_sh[2*N-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef DIV_SEQ_DZ_FAST_EN
          state_nxt = (b == '0) ? DONE : BUSY;
`else
          state_nxt = BUSY;
`endif
        end
      end
      BUSY: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_reg <= '0;
      rem   <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_reg <= b;
            rem   <= '0;
            cnt   <= '0;
`ifdef DIV_SEQ_DZ_FAST_EN
            if (b == '0) begin
              q  <= '1;
              r  <= '0;
              dz <= 1'b1;
            end
`endif
          end
        end
        BUSY: begin
          a_sh <= a_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            // A zero divisor runs through the iterations, and the
            // garbage it produces is replaced with the fixed result here.
            if (b_reg == '0) begin
              q  <= '1;
              r  <= '0;
              dz <= 1'b1;
            end else begin
              q  <= a_nxt;
              r  <= rem_nxt[N-1:0];
              dz <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int N   = 8;
  localparam int LAT = 2*N + 1;
`ifdef DIV_SEQ_DZ_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 2*N + 1;
`endif

  typedef logic [2*N-1:0] dvd_t;
  typedef logic [N-1:0]   dvs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  dvd_t a = '0;
  dvs_t b = '0;
  logic in_ready, out_valid, dz;
  dvd_t q;
  dvs_t r;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  function automatic dvd_t ref_q(input dvd_t x, input dvs_t y);
    if (y == 0) return '1;
    return dvd_t'(x / dvd_t'(y));
  endfunction

  function automatic dvs_t ref_r(input dvd_t x, input dvs_t y);
    if (y == 0) return '0;
    return dvs_t'(x % dvd_t'(y));
  endfunction

  // Drives one operand pair from IDLE and waits (bounded) for out_valid.
  task automatic run_op(input dvd_t ai, input dvs_t bi,
                        output dvd_t gq, output dvs_t gr, output logic gdz,
                        output int lat);
    a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = dvd_t'($urandom);
    b = dvs_t'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    gq = q; gr = r; gdz = dz;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 16'd77; b = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (q !== '0)           begin n_bad++; $display("FAIL reset_q got %h want 0", q); end
    n_cmp++; if (r !== '0)           begin n_bad++; $display("FAIL reset_r got %h want 0", r); end
    n_cmp++; if (dz !== 1'b0)        begin n_bad++; $display("FAIL reset_dz got %b want 0", dz); end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    dvd_t va [8] = '{16'd1000, 16'hFFFF, 16'd5,  16'hFFFF, 16'd1234, 16'd0, 16'd3,   16'd100};
    dvs_t vb [8] = '{8'd7,     8'hFF,    8'd10, 8'd1,     8'd0,     8'd5,  8'd200,  8'd3};
    dvd_t eq [8] = '{16'd142,  16'h0101, 16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0,   16'd33};
    dvs_t er [8] = '{8'd6,     8'd0,     8'd5,  8'd0,     8'd0,     8'd0,  8'd3,    8'd1};
    dvd_t gq; dvs_t gr; logic gdz; int lat; int elat; logic edz;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], gq, gr, gdz, lat);
      edz  = (vb[i] == 0);
      elat = edz ? DZ_LAT : LAT;
      n_cmp++; if (gq !== eq[i])  begin n_bad++; $display("FAIL dir%0d_q got %h want %h", i, gq, eq[i]); end
      n_cmp++; if (gr !== er[i])  begin n_bad++; $display("FAIL dir%0d_r got %h want %h", i, gr, er[i]); end
      n_cmp++; if (gdz !== edz)   begin n_bad++; $display("FAIL dir%0d_dz got %b want %b", i, gdz, edz); end
      n_cmp++; if (lat != elat)   begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat); end
      handoff();
    end
  endtask

  task automatic test_stall_ignore();
    dvd_t ea = 16'hABCD; dvs_t eb = 8'h37;
    dvd_t eq; dvs_t er;
    int lat;
    eq = ref_q(ea, eb); er = ref_r(ea, eb);
    a = ea; b = eb; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      in_valid = 1'($urandom_range(0, 1));
      a = dvd_t'($urandom); b = dvs_t'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL stall_latency got %0d want %0d", lat, LAT); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'(c & 1);
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== eq || r !== er || dz !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d got ov=%b ir=%b q=%h r=%h dz=%b want ov=1 ir=0 q=%h r=%h dz=0",
                 c, out_valid, in_ready, q, r, dz, eq, er);
      end
    end
    in_valid = 1'b0;
    handoff();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_return got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
    n_cmp++; if (q !== eq || r !== er) begin n_bad++; $display("FAIL stall_retain got q=%h r=%h want q=%h r=%h", q, r, eq, er); end
    begin
      logic seen = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        if (out_valid === 1'b1) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL stall_spurious_result got 1 want 0"); end
    end
  endtask

  task automatic test_reset_abort();
    dvd_t gq; dvs_t gr; logic gdz; int lat; logic seen;
    a = 16'd1000; b = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
    n_cmp++; if (q !== '0 || r !== '0 || dz !== 1'b0) begin n_bad++; $display("FAIL abort_outputs got q=%h r=%h dz=%b want 0", q, r, dz); end
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_result got 1 want 0"); end
    run_op(16'd100, 8'd3, gq, gr, gdz, lat);
    n_cmp++; if (gq !== 16'd33 || gr !== 8'd1 || gdz !== 1'b0 || lat != LAT) begin
      n_bad++; $display("FAIL abort_next_op got q=%0d r=%0d dz=%b lat=%0d want q=33 r=1 dz=0 lat=%0d", gq, gr, gdz, lat, LAT);
    end
    handoff();
  endtask

  task automatic test_back_to_back();
    dvd_t ai, eq; dvs_t bi, er; logic edz; int lat, elat;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0:       begin ai = dvd_t'($urandom); bi = '0; end
        1:       begin bi = dvs_t'($urandom_range(1, 255)); ai = dvd_t'($urandom_range(0, 32'(bi) - 1)); end
        2:       begin ai = '0; bi = dvs_t'($urandom); end
        default: begin ai = dvd_t'($urandom); bi = dvs_t'($urandom); end
      endcase
      eq = ref_q(ai, bi); er = ref_r(ai, bi); edz = (bi == 0);
      elat = edz ? DZ_LAT : LAT;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b%0d_ready got %b want 1", i, in_ready); end
      a = ai; b = bi; in_valid = 1'b1;
      @(posedge clk); #1;
      a = dvd_t'($urandom); b = dvs_t'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 64) begin
        @(posedge clk); #1;
        lat++;
      end
      n_cmp++;
      if (q !== eq || r !== er || dz !== edz || lat != elat) begin
        n_bad++;
        $display("FAIL b2b%0d a=%h b=%h got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                 i, ai, bi, q, r, dz, lat, eq, er, edz, elat);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b%0d_handoff got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
